// File: rtl/stack_cmd_sequencer.sv
// stack_cmd_sequencer
//   Upstream command stage for the W-bit stack. Commands from a producer are
//   buffered in a DEPTH-entry FIFO and issued one at a time as a single-cycle
//   apply pulse. After each issue the sequencer waits for the stack's valid
//   and reports the captured head/empty flags as a one-cycle result strobe.
//
//   Optional build macro: STACK_SEQ_TIMEOUT_EN
//     defined     - WAIT gives up after TMO cycles and reports with res_err=1
//     not defined - WAIT holds until stk_valid, res_err tied low
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/ready/op/data   producer handshake into the command FIFO
//   stk_op/in/apply           command to the stack (apply is a 1-cycle pulse)
//   stk_head/empty/valid      stack response
//   res_valid/data/empty/err  result strobe and held result fields
//   busy                      FSM active or FIFO holds commands
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting; pops the FIFO head into stk_op/stk_in when present
// S_ISSUE  | stk_apply high for this single cycle
// S_WAIT   | waiting for stk_valid (optionally bounded by TMO cycles)
// S_REPORT | res_valid high for this single cycle

module stack_cmd_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int TMO   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [3:0]   stk_op,
    output logic [W-1:0] stk_in,
    output logic         stk_apply,
    input  logic [W-1:0] stk_head,
    input  logic         stk_empty,
    input  logic         stk_valid,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_empty,
    output logic         res_err,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [3:0]     stk_op_q, stk_op_d;
    logic [W-1:0]   stk_in_q, stk_in_d;
    logic           stk_apply_q, stk_apply_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_empty_q, res_empty_d;
    logic           push, pop;

    logic [3:0]     op_mem   [DEPTH];
    logic [W-1:0]   data_mem [DEPTH];

`ifdef STACK_SEQ_TIMEOUT_EN
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic           res_err_q, res_err_d;
`endif

    // Full blocks pushes even when a pop happens the same cycle.
    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // Only registered count is consulted, so a fresh push pops next cycle at the earliest.
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]   <= cmd_op;
            data_mem[wr_ptr_q] <= cmd_data;
        end
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        state_d     = state_q;
        stk_op_d    = stk_op_q;
        stk_in_d    = stk_in_q;
        stk_apply_d = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_empty_d = res_empty_q;
`ifdef STACK_SEQ_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        res_err_d   = res_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    stk_op_d    = op_mem[rd_ptr_q];
                    stk_in_d    = data_mem[rd_ptr_q];
                    stk_apply_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef STACK_SEQ_TIMEOUT_EN
                tmo_cnt_d = TW'(TMO - 1);
`endif
            end
            S_WAIT: begin
                if (stk_valid) begin
                    res_data_d  = stk_head;
                    res_empty_d = stk_empty;
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
`ifdef STACK_SEQ_TIMEOUT_EN
                    res_err_d   = 1'b0;
                end else if (tmo_cnt_q == '0) begin
                    // TMO-th consecutive WAIT cycle without a response
                    res_data_d  = stk_head;
                    res_empty_d = stk_empty;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q - 1'b1;
`endif
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stk_op_q    <= '0;
            stk_in_q    <= '0;
            stk_apply_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_empty_q <= 1'b0;
`ifdef STACK_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stk_op_q    <= stk_op_d;
            stk_in_q    <= stk_in_d;
            stk_apply_q <= stk_apply_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_empty_q <= res_empty_d;
`ifdef STACK_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign stk_op    = stk_op_q;
    assign stk_in    = stk_in_q;
    assign stk_apply = stk_apply_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_empty = res_empty_q;
`ifdef STACK_SEQ_TIMEOUT_EN
    assign res_err   = res_err_q;
`else
    assign res_err   = 1'b0;
`endif
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
module tb_stack_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [3:0]  stk_op;
    logic [15:0] stk_in;
    logic        stk_apply;
    logic [15:0] stk_head;
    logic        stk_empty, stk_valid;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_empty, res_err, busy;

    logic [15:0] head_xor  = 16'h0;
    logic        empty_drv = 1'b0;
    logic        valid_drv = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int apply_long = 0;
    logic prev_apply = 1'b0;

    int          apply_cyc [$];
    logic [3:0]  apply_op  [$];
    int          res_cyc   [$];
    logic [15:0] res_d_q   [$];
    logic        res_e_q   [$];
    logic        res_r_q   [$];

    stack_cmd_sequencer #(.W(16), .DEPTH(4), .TMO(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .stk_op(stk_op), .stk_in(stk_in), .stk_apply(stk_apply),
        .stk_head(stk_head), .stk_empty(stk_empty), .stk_valid(stk_valid),
        .res_valid(res_valid), .res_data(res_data), .res_empty(res_empty),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // stack stand-in: head follows the operand, optionally scrambled
    assign stk_head  = stk_in ^ head_xor;
    assign stk_empty = empty_drv;
    assign stk_valid = valid_drv;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (stk_apply) begin
            apply_cyc.push_back(cyc);
            apply_op.push_back(stk_op);
        end
        if (stk_apply && prev_apply) apply_long++;
        prev_apply = stk_apply;
        if (res_valid) begin
            res_cyc.push_back(cyc);
            res_d_q.push_back(res_data);
            res_e_q.push_back(res_empty);
            res_r_q.push_back(res_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [3:0] op, input logic [15:0] data);
        logic got;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int i = 0; i < 200 && !got; i++) begin
            got = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("push_accept", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_res(input int n, input int limit);
        int i;
        i = 0;
        while (res_d_q.size() < n && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk("res_arrive", {31'b0, res_d_q.size() >= n}, 32'd1);
    endtask

    initial begin
        int br, ba;
        logic [15:0] exp3 [6];
        exp3[0] = 16'd13; exp3[1] = 16'd18; exp3[2] = 16'd21;
        exp3[3] = 16'd5;  exp3[4] = 16'd9;  exp3[5] = 16'd77;

        // 1: reset with a command offered
        rst = 1'b0; cmd_valid = 1'b1; cmd_op = 4'd1; cmd_data = 16'd1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_apply", {31'b0, stk_apply}, 32'd0);
        chk("rst_resv",  {31'b0, res_valid}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_rdata", {16'b0, res_data}, 32'd0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_noenq", {31'b0, busy}, 32'd0);
        chk("rst_noapp", apply_cyc.size(), 32'd0);

        // 2: single push
        push(4'd7, 16'd150);
        wait_res(1, 20);
        chk("s_data",  {16'b0, res_d_q[0]}, 32'd150);
        chk("s_empty", {31'b0, res_e_q[0]}, 32'd0);
        chk("s_err",   {31'b0, res_r_q[0]}, 32'd0);
        chk("s_napp",  apply_cyc.size(), 32'd1);
        chk("s_op",    {28'b0, apply_op[0]}, 32'd7);
        @(negedge clk);
        chk("s_hold",  {16'b0, res_data}, 32'd150);
        chk("s_idle",  {31'b0, busy}, 32'd0);

        // 3: burst while the stack stalls, filling the FIFO
        br = res_d_q.size(); ba = apply_cyc.size();
        valid_drv = 1'b0;
        push(4'd2, 16'd13);
        push(4'd2, 16'd18);
        push(4'd2, 16'd21);
        push(4'd2, 16'd5);
        push(4'd2, 16'd9);
        chk("b_full", {31'b0, cmd_ready}, 32'd0);
        chk("b_busy", {31'b0, busy}, 32'd1);
        valid_drv = 1'b1;
        push(4'd2, 16'd77);
        wait_res(br + 6, 60);
        for (int k = 0; k < 6; k++) chk("b_order", {16'b0, res_d_q[br+k]}, {16'b0, exp3[k]});
        for (int k = 1; k < 5; k++)
            chk("b_space", apply_cyc[ba+k+1] - apply_cyc[ba+k], 32'd4);

        // 4: continuous stream through the wrapping FIFO, scrambled head
        repeat (2) @(negedge clk);
        br = res_d_q.size(); ba = apply_cyc.size();
        empty_drv = 1'b1; head_xor = 16'h00F0;
        for (int i = 0; i < 10; i++) push(4'(i), 16'(100 + i));
        wait_res(br + 10, 80);
        repeat (6) @(negedge clk);
        chk("w_count", res_d_q.size() - br, 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("w_data", {16'b0, res_d_q[br+i]}, {16'b0, 16'(100 + i) ^ 16'h00F0});
            chk("w_op",   {28'b0, apply_op[ba+i]}, 32'(i));
        end
        chk("w_empty", {31'b0, res_e_q[br+9]}, 32'd1);
        empty_drv = 1'b0; head_xor = 16'h0;

        // 5: reset during WAIT
        br = res_d_q.size(); ba = apply_cyc.size();
        valid_drv = 1'b0;
        push(4'd3, 16'd42);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("r_apply", {31'b0, stk_apply}, 32'd0);
        chk("r_busy",  {31'b0, busy}, 32'd0);
        chk("r_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1; valid_drv = 1'b1;
        repeat (10) @(negedge clk);
        chk("r_nores", res_d_q.size(), br);
        chk("r_napp",  apply_cyc.size(), ba + 1);
        chk("r_idle",  {31'b0, busy}, 32'd0);

        // 6: stack never answers
        br = res_d_q.size(); ba = apply_cyc.size();
        valid_drv = 1'b0; head_xor = 16'h1111; empty_drv = 1'b1;
        push(4'd9, 16'd55);
`ifdef STACK_SEQ_TIMEOUT_EN
        wait_res(br + 1, 30);
        chk("t_lat",   res_cyc[br] - apply_cyc[ba], 32'd9);
        chk("t_err",   {31'b0, res_r_q[br]}, 32'd1);
        chk("t_data",  {16'b0, res_d_q[br]}, {16'b0, 16'd55 ^ 16'h1111});
        chk("t_empty", {31'b0, res_e_q[br]}, 32'd1);
`else
        repeat (30) @(negedge clk);
        chk("t_nores", res_d_q.size(), br);
        chk("t_busy",  {31'b0, busy}, 32'd1);
        valid_drv = 1'b1;
        wait_res(br + 1, 10);
        chk("t_err",   {31'b0, res_r_q[br]}, 32'd0);
        chk("t_data",  {16'b0, res_d_q[br]}, {16'b0, 16'd55 ^ 16'h1111});
`endif
        valid_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk("apply_1cyc", apply_long, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
